alu_cmd_driver: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/alu_cmd_driver.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, burst size, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MAC = 4'b1000;
    localparam logic [3:0] OP_MAT = 4'b1001;

    // Beats per matrix burst and the width of the beat index carried with each result.
    localparam int MAT_N     = 8;
    localparam int IDX_W     = 3;
    // Result record {inst, idx, data} at default widths.
    localparam int RES_REC_W = 4 + IDX_W + 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    function automatic logic is_mat(input logic [3:0] op);
        return op == OP_MAT;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/count; head is visible combinationally on o_dout.
// Latency: push visible at o_dout/o_empty one cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored.
// Ports: i_clk, i_rst_n, i_push/i_din, i_pop, o_dout, o_full, o_empty, o_count.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_dout  = mem[rd_ptr];
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;

endmodule

// File: rtl/alu_cmd_driver.sv
// Buffers host commands, issues them to the ALU (matrix ops as MAT_N-beat bursts), collects tagged results.
// Latency: cmd push to o_alu_valid >= 2 cycles when idle; i_alu_out_valid to o_res_valid 1 cycle.
// Backpressure: o_cmd_ready drops when the command FIFO is full; issue waits for !i_alu_busy and result-FIFO room.
// Ports: host cmd (i_cmd_*/o_cmd_ready), ALU operand bus (o_alu_*, i_alu_busy), ALU result (i_alu_out_valid,
//        i_alu_data), host result (o_res_*, i_res_ready), status (o_idle, o_err_proto, o_err_timeout).
module alu_cmd_driver #(
    parameter int INST_W    = 4,
    parameter int DATA_W    = 16,
    parameter int CMD_DEPTH = 8,
    parameter int RES_DEPTH = 8,
    parameter int MAT_N     = alu_pkg::MAT_N,
    parameter int TIMEOUT   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [INST_W-1:0] i_cmd_inst,
    input  logic [DATA_W-1:0] i_cmd_a,
    input  logic [DATA_W-1:0] i_cmd_b,
    output logic              o_alu_valid,
    input  logic              i_alu_busy,
    output logic [INST_W-1:0] o_alu_inst,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic              i_alu_out_valid,
    input  logic [DATA_W-1:0] i_alu_data,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [DATA_W-1:0] o_res_data,
    output logic [INST_W-1:0] o_res_inst,
    output logic [2:0]        o_res_idx,
    output logic              o_idle,
    output logic              o_err_proto,
    output logic              o_err_timeout
);

    import alu_pkg::*;

    localparam int CMD_W  = INST_W + 2*DATA_W;
    localparam int RW     = INST_W + IDX_W + DATA_W;
    localparam int CCNT_W = $clog2(CMD_DEPTH) + 1;
    localparam int RCNT_W = $clog2(RES_DEPTH) + 1;
    localparam int BEAT_W = (MAT_N > 1) ? $clog2(MAT_N) : 1;
    localparam int EXP_W  = $clog2(MAT_N + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    state_t              state, state_nxt;

    // Command FIFO
    logic                cmd_full, cmd_empty, cmd_pop;
    logic [CMD_W-1:0]    cmd_dout;
    logic [CCNT_W-1:0]   cmd_count;
    logic [INST_W-1:0]   head_inst;
    logic [DATA_W-1:0]   head_a, head_b;
    logic                head_is_mat;

    // Result FIFO
    logic                res_full, res_empty, res_push, res_pop;
    logic [RW-1:0]       res_din, res_dout;
    logic [RCNT_W-1:0]   res_count, res_free, res_need;

    // Control strobes from the next-state logic
    logic                fire, drop, enter_wait, tmo_hit, unexpected;
    logic [EXP_W-1:0]    exp_load;

    // Sequencing state
    logic [INST_W-1:0]   cur_inst;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [EXP_W-1:0]    exp_cnt;
    logic [IDX_W-1:0]    res_idx;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                err_proto, err_timeout;
    logic                unused_ok;

    sync_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_cmd_valid),
        .i_din   ({i_cmd_inst, i_cmd_a, i_cmd_b}),
        .i_pop   (cmd_pop),
        .o_dout  (cmd_dout),
        .o_full  (cmd_full),
        .o_empty (cmd_empty),
        .o_count (cmd_count)
    );

    sync_fifo #(.W(RW), .DEPTH(RES_DEPTH)) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (res_push),
        .i_din   (res_din),
        .i_pop   (res_pop),
        .o_dout  (res_dout),
        .o_full  (res_full),
        .o_empty (res_empty),
        .o_count (res_count)
    );

    assign unused_ok   = ^{cmd_count, res_full};

    assign head_inst   = cmd_dout[CMD_W-1 -: INST_W];
    assign head_a      = cmd_dout[2*DATA_W-1 -: DATA_W];
    assign head_b      = cmd_dout[DATA_W-1:0];
    assign head_is_mat = is_mat(head_inst);

    // Slots are reserved up front so a whole burst's results always fit.
    assign res_free    = RCNT_W'(RES_DEPTH) - res_count;
    assign res_need    = head_is_mat ? RCNT_W'(MAT_N) : RCNT_W'(1);

    assign res_din     = {cur_inst, res_idx, i_alu_data};
    assign res_pop     = i_res_ready && !res_empty;
    assign unexpected  = i_alu_out_valid && (state != S_WAIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_pop    = 1'b0;
        fire       = 1'b0;
        drop       = 1'b0;
        enter_wait = 1'b0;
        exp_load   = '0;
        res_push   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cmd_empty && (res_free >= res_need)) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!cmd_empty) begin
                    // A nonzero beat count means a burst is open: anything else at the head is discarded.
                    if ((beat_cnt != '0) && !head_is_mat) begin
                        cmd_pop = 1'b1;
                        drop    = 1'b1;
                    end else if (!i_alu_busy) begin
                        cmd_pop = 1'b1;
                        fire    = 1'b1;
                        if (!head_is_mat) begin
                            state_nxt  = S_WAIT;
                            enter_wait = 1'b1;
                            exp_load   = EXP_W'(1);
                        end else if (beat_cnt == BEAT_W'(MAT_N - 1)) begin
                            state_nxt  = S_WAIT;
                            enter_wait = 1'b1;
                            exp_load   = EXP_W'(MAT_N);
                        end
                    end
                end
            end
            S_WAIT: begin
                if (i_alu_out_valid) begin
                    res_push = 1'b1;
                    if (exp_cnt == EXP_W'(1)) begin
                        state_nxt = S_IDLE;
                    end
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_valid <= 1'b0;
            o_alu_inst  <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            cur_inst    <= '0;
            beat_cnt    <= '0;
            exp_cnt     <= '0;
            res_idx     <= '0;
            tmo_cnt     <= '0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            o_alu_valid <= fire;
            if (fire) begin
                o_alu_inst <= head_inst;
                o_alu_a    <= head_a;
                o_alu_b    <= head_b;
                cur_inst   <= head_inst;
                if (head_is_mat) begin
                    beat_cnt <= (beat_cnt == BEAT_W'(MAT_N - 1)) ? '0 : beat_cnt + BEAT_W'(1);
                end
            end
            if (enter_wait) begin
                exp_cnt <= exp_load;
                res_idx <= '0;
                tmo_cnt <= '0;
            end else if (res_push) begin
                exp_cnt <= exp_cnt - EXP_W'(1);
                res_idx <= res_idx + IDX_W'(1);
                tmo_cnt <= '0;
            end else if (tmo_hit) begin
                exp_cnt <= '0;
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (drop || unexpected) begin
                err_proto <= 1'b1;
            end
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign o_cmd_ready   = !cmd_full;
    assign o_res_valid   = !res_empty;
    // Result fields are forced to zero when empty so stale FIFO storage never shows.
    assign o_res_data    = res_empty ? '0 : res_dout[DATA_W-1:0];
    assign o_res_idx     = res_empty ? '0 : res_dout[DATA_W +: IDX_W];
    assign o_res_inst    = res_empty ? '0 : res_dout[RW-1 -: INST_W];
    assign o_idle        = cmd_empty && res_empty && (state == S_IDLE);
    assign o_err_proto   = err_proto;
    assign o_err_timeout = err_timeout;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU responder and a result scoreboard.
// Latency: n/a.
// Backpressure: exercises i_alu_busy and i_res_ready stalls.
module tb_alu_cmd_driver;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [3:0]  i_cmd_inst;
    logic [15:0] i_cmd_a, i_cmd_b;
    logic        o_alu_valid;
    logic        i_alu_busy;
    logic [3:0]  o_alu_inst;
    logic [15:0] o_alu_a, o_alu_b;
    logic        i_alu_out_valid;
    logic [15:0] i_alu_data;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [15:0] o_res_data;
    logic [3:0]  o_res_inst;
    logic [2:0]  o_res_idx;
    logic        o_idle, o_err_proto, o_err_timeout;

    alu_cmd_driver dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_cmd_valid     (i_cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_inst      (i_cmd_inst),
        .i_cmd_a         (i_cmd_a),
        .i_cmd_b         (i_cmd_b),
        .o_alu_valid     (o_alu_valid),
        .i_alu_busy      (i_alu_busy),
        .o_alu_inst      (o_alu_inst),
        .o_alu_a         (o_alu_a),
        .o_alu_b         (o_alu_b),
        .i_alu_out_valid (i_alu_out_valid),
        .i_alu_data      (i_alu_data),
        .o_res_valid     (o_res_valid),
        .i_res_ready     (i_res_ready),
        .o_res_data      (o_res_data),
        .o_res_inst      (o_res_inst),
        .o_res_idx       (o_res_idx),
        .o_idle          (o_idle),
        .o_err_proto     (o_err_proto),
        .o_err_timeout   (o_err_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0]  inst;
        logic [2:0]  idx;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  inst;
        logic [15:0] data;
        int          cyc;
    } beat_t;

    int     n_vec = 0;
    int     n_err = 0;
    exp_t   exp_q[$];
    beat_t  alu_q[$];
    int     pulse_cyc[$];
    int     alu_pulses = 0;
    int     cyc = 0;
    int     mat_pend = 0;
    int     mat_rel = 0;
    int     inject_req = 0;
    int     inject_ack = 0;
    bit     alu_silent = 1'b0;
    logic   busy_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] inst, input logic [2:0] idx, input logic [15:0] d);
        exp_q.push_back({inst, idx, d});
    endtask

    task automatic push_cmd(input logic [3:0] inst, input logic [15:0] a, input logic [15:0] b);
        int g = 0;
        i_cmd_valid = 1'b1;
        i_cmd_inst  = inst;
        i_cmd_a     = a;
        i_cmd_b     = b;
        while (!o_cmd_ready && g < 200) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (g >= 200) check("cmd_ready_wait", 0, 1);
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (!(exp_q.size() == 0 && o_idle) && g < 400) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (g >= 400) check({name, "_drain_timeout"}, exp_q.size(), 0);
    endtask

    task automatic wait_pulses(input int target, input string name);
        int g = 0;
        while (alu_pulses < target && g < 200) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (g >= 200) check({name, "_pulse_timeout"}, alu_pulses, target);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_alu_valid"},   o_alu_valid,   0);
        check({tag, "_alu_inst"},    o_alu_inst,    0);
        check({tag, "_alu_a"},       o_alu_a,       0);
        check({tag, "_alu_b"},       o_alu_b,       0);
        check({tag, "_cmd_ready"},   o_cmd_ready,   1);
        check({tag, "_idle"},        o_idle,        1);
        check({tag, "_res_valid"},   o_res_valid,   0);
        check({tag, "_res_data"},    o_res_data,    0);
        check({tag, "_res_inst"},    o_res_inst,    0);
        check({tag, "_res_idx"},     o_res_idx,     0);
        check({tag, "_err_proto"},   o_err_proto,   0);
        check({tag, "_err_timeout"}, o_err_timeout, 0);
    endtask

    always @(posedge i_clk) busy_q <= i_alu_busy;

    // ALU stand-in: answers a+b two cycles after a scalar beat; matrix results are
    // released only once all eight beats of the burst have been received.
    initial begin
        logic [15:0] sum;
        beat_t       b;
        i_alu_out_valid = 1'b0;
        i_alu_data      = '0;
        forever begin
            @(posedge i_clk); #1;
            cyc++;
            i_alu_out_valid = 1'b0;
            if (!i_rst_n) begin
                alu_q.delete();
                mat_pend = 0;
                mat_rel  = 0;
            end else begin
                if (o_alu_valid) begin
                    alu_pulses++;
                    pulse_cyc.push_back(cyc);
                    check("busy_respect", busy_q, 0);
                    if (!alu_silent) begin
                        sum = o_alu_a + o_alu_b;
                        alu_q.push_back('{o_alu_inst, sum, cyc});
                        if (o_alu_inst == 4'd9) begin
                            mat_pend++;
                            if (mat_pend == 8) begin
                                mat_rel += 8;
                                mat_pend = 0;
                            end
                        end
                    end
                end
                if (inject_req != inject_ack) begin
                    inject_ack++;
                    i_alu_out_valid = 1'b1;
                    i_alu_data      = 16'hDEAD;
                end else if (alu_q.size() > 0 && cyc >= alu_q[0].cyc + 2 &&
                             (alu_q[0].inst != 4'd9 || mat_rel > 0)) begin
                    b = alu_q.pop_front();
                    if (b.inst == 4'd9) mat_rel--;
                    i_alu_out_valid = 1'b1;
                    i_alu_data      = b.data;
                end
            end
        end
    end

    // Scoreboard monitor: compares every result the host pops.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                exp_q.delete();
            end else if (o_res_valid && i_res_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL res_unexpected: got data %0h inst %0h idx %0h, required no result",
                             o_res_data, o_res_inst, o_res_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", o_res_data, e.data);
                    check("res_inst", o_res_inst, e.inst);
                    check("res_idx",  o_res_idx,  e.idx);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pbase;
        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_inst  = '0;
        i_cmd_a     = '0;
        i_cmd_b     = '0;
        i_alu_busy  = 1'b0;
        i_res_ready = 1'b1;

        cycles(3);
        check_reset_vals("por");
        i_rst_n = 1'b1;
        cycles(2);
        check("por_idle_after", o_idle, 1);

        // Scalar add
        base = alu_pulses;
        push_exp(4'd0, 3'd0, 16'h0C00);
        push_cmd(4'd0, 16'h0400, 16'h0800);
        wait_drain("scalar");
        check("scalar_pulses", alu_pulses - base, 1);
        check("scalar_idle", o_idle, 1);

        // Matrix burst, a = k, b = 0x0100
        base  = alu_pulses;
        pbase = pulse_cyc.size();
        for (int k = 0; k < 8; k++) push_exp(4'd9, 3'(k), 16'h0100 + 16'(k));
        for (int k = 0; k < 8; k++) push_cmd(4'd9, 16'(k), 16'h0100);
        wait_drain("mat");
        check("mat_pulses", alu_pulses - base, 8);
        if (pulse_cyc.size() >= pbase + 8)
            check("mat_consecutive", pulse_cyc[pbase+7] - pulse_cyc[pbase], 7);
        else
            check("mat_pulse_count", pulse_cyc.size() - pbase, 8);

        // Busy respect
        base = alu_pulses;
        i_alu_busy = 1'b1;
        push_exp(4'd0, 3'd0, 16'h0003);
        push_cmd(4'd0, 16'h0001, 16'h0002);
        cycles(5);
        check("busy_hold", alu_pulses - base, 0);
        i_alu_busy = 1'b0;
        wait_drain("busy");
        check("busy_release", alu_pulses - base, 1);

        // Result back-pressure: 7 results parked, matrix head must wait for 8 free slots
        base = alu_pulses;
        i_res_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push_exp(4'd0, 3'd0, 16'h1000 + 16'(i));
            push_cmd(4'd0, 16'(i), 16'h1000);
        end
        wait_pulses(base + 7, "bp_scalar");
        cycles(5);
        check("bp_res_valid", o_res_valid, 1);
        for (int k = 0; k < 8; k++) push_exp(4'd9, 3'(k), 16'h2000 + 16'(k));
        for (int k = 0; k < 8; k++) push_cmd(4'd9, 16'(k), 16'h2000);
        cycles(20);
        check("bp_no_issue", alu_pulses - base, 7);
        i_res_ready = 1'b1;
        wait_drain("bp");
        check("bp_burst_done", alu_pulses - base, 15);

        // Non-matrix command inside a burst is dropped and flagged
        check("proto_before", o_err_proto, 0);
        base = alu_pulses;
        for (int k = 0; k < 8; k++) push_exp(4'd9, 3'(k), 16'h0300 + 16'(k));
        for (int k = 0; k < 3; k++) push_cmd(4'd9, 16'(k), 16'h0300);
        push_cmd(4'd0, 16'hFFFF, 16'h0001);
        for (int k = 3; k < 8; k++) push_cmd(4'd9, 16'(k), 16'h0300);
        wait_drain("proto");
        check("proto_flag", o_err_proto, 1);
        check("proto_beats", alu_pulses - base, 8);
        check("proto_no_timeout", o_err_timeout, 0);

        // Reset in the middle of a burst
        base = alu_pulses;
        for (int k = 0; k < 4; k++) push_cmd(4'd9, 16'(k), 16'h0000);
        wait_pulses(base + 4, "rst_mid");
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        cycles(2);
        i_rst_n = 1'b1;
        cycles(3);
        check("rst_idle_after", o_idle, 1);
        check("rst_no_issue", alu_pulses - base, 4);

        // Silent ALU: timeout after 32 waiting cycles
        alu_silent = 1'b1;
        base = alu_pulses;
        push_cmd(4'd0, 16'h0005, 16'h0006);
        wait_pulses(base + 1, "tmo");
        cycles(20);
        check("tmo_early", o_err_timeout, 0);
        cycles(20);
        check("tmo_flag", o_err_timeout, 1);
        check("tmo_idle", o_idle, 1);
        alu_silent = 1'b0;

        // Result with nothing outstanding
        check("unexp_before", o_err_proto, 0);
        inject_req++;
        cycles(4);
        check("unexp_flag", o_err_proto, 1);
        check("unexp_dropped", o_res_valid, 0);
        check("sticky_timeout", o_err_timeout, 1);

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
